// File: rtl/imm_ext_pkg.sv
// Shared types and opcode match patterns for the LEGv8 immediate extraction stage.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_MOV  = 3'd5
    } imm_fmt_t;

    // Match patterns on instr[31:21]; '?' bits are don't-care in casez.
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CB   = 11'b1011010????;
    localparam logic [10:0] OP_B    = 11'b000101?????;
    localparam logic [10:0] OP_I    = 11'b1?01000100?;
    localparam logic [10:0] OP_MOV  = 11'b110100101??;

endpackage

// File: rtl/imm_ext_stage_decode.sv
// Combinational immediate decoder: instruction word to extended immediate and format tag.
module imm_decode
    import imm_ext_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [31:0]  in_instr,
    output logic [N-1:0] imm,
    output logic [2:0]   fmt
);

    logic signed [8:0]  d_off;
    logic signed [20:0] cb_off;
    logic signed [27:0] b_off;
    logic [63:0]        mov_wide;
    logic               unused_low;

    assign unused_low = ^in_instr[4:0];

    always_comb begin
        imm      = '0;
        fmt      = FMT_NONE;
        d_off    = in_instr[20:12];
        cb_off   = {in_instr[23:5], 2'b00};
        b_off    = {in_instr[25:0], 2'b00};
        // Shift at 64 bits, then truncate so narrow builds drop high halfwords.
        mov_wide = 64'(in_instr[20:5]) << {in_instr[22:21], 4'b0000};
        casez (in_instr[31:21])
            OP_LDUR, OP_STUR: begin
                fmt = FMT_D;
                imm = N'(d_off);
            end
            OP_CB: begin
                fmt = FMT_CB;
                imm = N'(cb_off);
            end
            OP_B: begin
                fmt = FMT_B;
                imm = N'(b_off);
            end
            OP_I: begin
                fmt = FMT_I;
                imm = N'(in_instr[21:10]);
            end
            OP_MOV: begin
                fmt = FMT_MOV;
                imm = mov_wide[N-1:0];
            end
            default: begin
                fmt = FMT_NONE;
                imm = '0;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Immediate extraction stage: decode on input, 2-entry FIFO toward decode, flush on redirect.
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int N     = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [N-1:0]     imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t       mem [2];
    entry_t       dec_entry;
    logic [1:0]   count;
    logic         head;
    logic         tail;
    logic         push;
    logic         pop;
    logic [N-1:0] dec_imm;
    logic [2:0]   dec_fmt;

    imm_decode #(.N(N)) u_decode (
        .in_instr (in_instr),
        .imm      (dec_imm),
        .fmt      (dec_fmt)
    );

    assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, tag: in_tag};

    always_comb begin
        in_ready  = (count != 2'd2);
        out_valid = (count != 2'd0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
        out_imm   = '0;
        out_fmt   = FMT_NONE;
        out_tag   = '0;
        if (out_valid) begin
            out_imm = mem[head].imm;
            out_fmt = mem[head].fmt;
            out_tag = mem[head].tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= dec_entry;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Randomized self-checking bench for imm_ext_stage (N=64 and N=32 instances in lockstep).
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_tag;

    logic        in_ready64, out_valid64, in_ready32, out_valid32;
    logic [63:0] out_imm64, out_tag64, out_tag32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt64, out_fmt32;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tag;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    imm_ext_stage #(.N(64), .TAG_W(64)) u64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
    );

    imm_ext_stage #(.N(32), .TAG_W(64)) u32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_tag(out_tag32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decode from the format rules, using plain integer arithmetic.
    function automatic void ref_decode(input logic [31:0] a, output logic [2:0] f,
                                       output logic [63:0] imm);
        longint v;
        v = 0;
        f = 3'd0;
        if (a[31:21] == 11'h7C2 || a[31:21] == 11'h7C0) begin
            f = 3'd1;
            v = longint'(a[20:12]);
            if (v >= 256) v -= 512;
        end else if (a[31:25] == 7'b1011010) begin
            f = 3'd2;
            v = longint'(a[23:5]);
            if (v >= (1 << 18)) v -= (1 << 19);
            v *= 4;
        end else if (a[31:26] == 6'b000101) begin
            f = 3'd3;
            v = longint'(a[25:0]);
            if (v >= (1 << 25)) v -= (1 << 26);
            v *= 4;
        end else if (a[31] == 1'b1 && a[29:22] == 8'h44) begin
            f = 3'd4;
            v = longint'(a[21:10]);
        end else if (a[31:23] == 9'b110100101) begin
            f = 3'd5;
            v = longint'(a[20:5]) * longint'(64'd1 << (16 * a[22:21]));
        end
        imm = 64'(v);
    endfunction

    // One clock: check outputs against the model, then advance the model on the edge.
    task automatic cycle();
        ent_t e;
        logic push, pop;
        @(negedge clk);
        if (q.size() == 0) begin
            e.imm = '0; e.fmt = 3'd0; e.tag = '0;
        end else begin
            e = q[0];
        end
        check("valid64", 64'(out_valid64), 64'(q.size() != 0));
        check("ready64", 64'(in_ready64), 64'(q.size() < 2));
        check("imm64", out_imm64, e.imm);
        check("fmt64", 64'(out_fmt64), 64'(e.fmt));
        check("tag64", out_tag64, e.tag);
        check("valid32", 64'(out_valid32), 64'(q.size() != 0));
        check("ready32", 64'(in_ready32), 64'(q.size() < 2));
        check("imm32", 64'(out_imm32), 64'(e.imm[31:0]));
        check("fmt32", 64'(out_fmt32), 64'(e.fmt));
        check("tag32", out_tag32, e.tag);
        push = in_valid && (q.size() < 2) && !flush;
        pop  = (q.size() > 0) && out_ready && !flush;
        ref_decode(in_instr, e.fmt, e.imm);
        e.tag = in_tag;
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r[31:21] = 11'h7C2;
            1: r[31:21] = 11'h7C0;
            2: r[31:25] = 7'b1011010;
            3: r[31:26] = 6'b000101;
            4: begin r[31] = 1'b1; r[29:22] = 8'h44; end
            5: r[31:23] = 9'b110100101;
            default: ;
        endcase
        return r;
    endfunction

    logic [31:0] seq_instr [4];
    logic [63:0] seq_imm [4];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        cycle(); cycle();
        reset = 1'b0;
        check("rst_valid", 64'(out_valid64), 64'd0);
        check("rst_ready", 64'(in_ready64), 64'd1);

        // Single LDUR #-1
        in_valid = 1'b1; in_instr = 32'hF85FF041; in_tag = 64'h100; out_ready = 1'b1;
        cycle();
        check("ldur_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ldur_fmt", 64'(out_fmt64), 64'd1);
        check("ldur_tag", out_tag64, 64'h100);

        // Back-to-back, one per cycle
        seq_instr[0] = 32'hB4FFFFE0; seq_imm[0] = 64'hFFFF_FFFF_FFFF_FFFC;
        seq_instr[1] = 32'h14000001; seq_imm[1] = 64'h4;
        seq_instr[2] = 32'h913FFC00; seq_imm[2] = 64'hFFF;
        seq_instr[3] = 32'hD2D7DDE0; seq_imm[3] = 64'h0000_BEEF_0000_0000;
        for (int i = 0; i < 4; i++) begin
            in_instr = seq_instr[i]; in_tag = 64'h200 + 64'(i);
            cycle();
            check("b2b_imm", out_imm64, seq_imm[i]);
            check("b2b_valid", 64'(out_valid64), 64'd1);
        end
        check("mov32_imm", 64'(out_imm32), 64'd0);
        in_valid = 1'b0;
        cycle();

        // Back-pressure: two accepted, third held until after first pop
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_instr = rand_instr(); in_tag = 64'h300 + 64'(i);
            cycle();
        end
        check("bp_ready", 64'(in_ready64), 64'd0);
        in_instr = rand_instr(); in_tag = 64'h302;
        cycle();
        check("bp_hold", 64'(in_ready64), 64'd0);
        out_ready = 1'b1;
        cycle();
        check("bp_reopen", 64'(in_ready64), 64'd1);
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();

        // Count=1 with push and pop every cycle
        out_ready = 1'b0; in_valid = 1'b1; in_instr = rand_instr(); in_tag = 64'h400;
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_instr = rand_instr(); in_tag = 64'h401 + 64'(i);
            cycle();
            check("c1_ready", 64'(in_ready64), 64'd1);
            check("c1_valid", 64'(out_valid64), 64'd1);
        end
        in_valid = 1'b0;
        cycle();

        // Flush when full, with input offered
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin in_instr = rand_instr(); in_tag = 64'h500; cycle(); end
        flush = 1'b1; in_instr = 32'hF85FF041; in_tag = 64'h5FF;
        cycle();
        check("fl_valid", 64'(out_valid64), 64'd0);
        check("fl_ready", 64'(in_ready64), 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        check("fl_gone", 64'(out_valid64), 64'd0);

        // Non-immediate instruction is forwarded as FMT_NONE
        in_valid = 1'b1; in_instr = 32'h8B000000; in_tag = 64'h600; out_ready = 1'b1;
        cycle();
        check("none_valid", 64'(out_valid32), 64'd1);
        check("none_fmt", 64'(out_fmt32), 64'd0);
        check("none_imm", 64'(out_imm32), 64'd0);
        in_valid = 1'b0;
        cycle();

        // Reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin in_instr = rand_instr(); in_tag = 64'h700; cycle(); end
        reset = 1'b1;
        cycle();
        check("mrst_valid", 64'(out_valid64), 64'd0);
        check("mrst_fmt", 64'(out_fmt64), 64'd0);
        reset = 1'b0; in_valid = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            in_instr  = rand_instr();
            in_tag    = {$urandom, $urandom};
            cycle();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
